// File: rtl/rs232_pkg.sv
// Shared definitions for the RS-232 Avalon-MM slave: register map, STATUS
// bit positions, serial FSM state encodings and the STATUS word packer.
package rs232_pkg;

    // Byte addresses of the three mapped registers
    localparam logic [4:0] RX_BASE     = 5'd0;
    localparam logic [4:0] TX_BASE     = 5'd4;
    localparam logic [4:0] STATUS_BASE = 5'd8;

    // STATUS bit positions
    localparam int RRDY = 7;
    localparam int TRDY = 6;
    localparam int TMT  = 5;
    localparam int ROE  = 3;
    localparam int FE   = 2;
    localparam int TOE  = 1;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_START = 2'd1,
        R_DATA  = 2'd2,
        R_STOP  = 2'd3
    } rx_state_t;

    typedef enum logic [1:0] {
        T_IDLE  = 2'd0,
        T_START = 2'd1,
        T_DATA  = 2'd2,
        T_STOP  = 2'd3
    } tx_state_t;

    // Packs the individual flags into the 32-bit STATUS read word
    function automatic logic [31:0] status_word(input logic rrdy, input logic trdy,
                                                input logic tmt,  input logic roe,
                                                input logic fe,   input logic toe);
        logic [31:0] w;
        w       = 32'd0;
        w[RRDY] = rrdy;
        w[TRDY] = trdy;
        w[TMT]  = tmt;
        w[ROE]  = roe;
        w[FE]   = fe;
        w[TOE]  = toe;
        return w;
    endfunction

endpackage

// File: rtl/rs232_rx_core.sv
// 8N1 serial receiver.
// Ports:
//   avm_clk, avm_rst : clock, asynchronous active-high reset
//   rxd_i            : raw asynchronous serial input
//   valid_o          : one-cycle pulse when a frame's stop bit is sampled
//   data_o           : received byte, valid with valid_o
//   fe_o             : stop bit was low, valid with valid_o
module rs232_rx_core
    import rs232_pkg::*;
#(
    parameter int DIV = 16
) (
    input  logic       avm_clk,
    input  logic       avm_rst,
    input  logic       rxd_i,
    output logic       valid_o,
    output logic [7:0] data_o,
    output logic       fe_o
);

    localparam int BW = $clog2(DIV);
    localparam logic [BW-1:0] FULL_BIT = BW'(DIV - 1);
    localparam logic [BW-1:0] HALF_BIT = BW'(DIV / 2 - 1);
    localparam logic [BW-1:0] ZERO     = BW'(0);
    localparam logic [BW-1:0] ONE      = BW'(1);

    rx_state_t     state_q, state_d;
    logic [BW-1:0] baud_q,  baud_d;
    logic [2:0]    bit_q,   bit_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          sync1_q, sync2_q;
    logic          rxd_s;

    assign rxd_s  = sync2_q;
    assign data_o = shreg_q;

    // Synchronizer (idles high so reset does not fake a start bit) and FSM state
    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= R_IDLE;
            baud_q  <= {BW{1'b0}};
            bit_q   <= 3'd0;
            shreg_q <= 8'd0;
        end else begin
            sync1_q <= rxd_i;
            sync2_q <= sync1_q;
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
        end
    end

    // Receive FSM: mid-bit sampling driven by the down-counting baud counter
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        valid_o = 1'b0;
        fe_o    = 1'b0;
        case (state_q)
            R_IDLE: begin
                if (!rxd_s) begin
                    state_d = R_START;
                    baud_d  = HALF_BIT;
                end else begin
                    state_d = R_IDLE;
                end
            end
            R_START: begin
                if (baud_q == ZERO) begin
                    // Line back high at mid start bit: treat as a glitch
                    if (!rxd_s) begin
                        state_d = R_DATA;
                        baud_d  = FULL_BIT;
                        bit_d   = 3'd0;
                    end else begin
                        state_d = R_IDLE;
                    end
                end else begin
                    baud_d = baud_q - ONE;
                end
            end
            R_DATA: begin
                if (baud_q == ZERO) begin
                    shreg_d = {rxd_s, shreg_q[7:1]};
                    baud_d  = FULL_BIT;
                    if (bit_q == 3'd7) begin
                        state_d = R_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q - ONE;
                end
            end
            R_STOP: begin
                if (baud_q == ZERO) begin
                    // Leave at mid stop bit so a back-to-back start edge is seen
                    valid_o = 1'b1;
                    fe_o    = ~rxd_s;
                    state_d = R_IDLE;
                end else begin
                    baud_d = baud_q - ONE;
                end
            end
            default: begin
                state_d = R_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/rs232_tx_core.sv
// 8N1 serial transmitter with a registered, glitch-free output.
// Ports:
//   avm_clk, avm_rst : clock, asynchronous active-high reset (txd_o -> 1)
//   hold_full_i      : holding register contains a byte to send
//   hold_data_i      : the holding register byte
//   take_o           : one-cycle pulse, byte moved from holding to shifter
//   busy_o           : shifter active (a frame is in progress)
//   txd_o            : serial output, idle high
module rs232_tx_core
    import rs232_pkg::*;
#(
    parameter int DIV = 16
) (
    input  logic       avm_clk,
    input  logic       avm_rst,
    input  logic       hold_full_i,
    input  logic [7:0] hold_data_i,
    output logic       take_o,
    output logic       busy_o,
    output logic       txd_o
);

    localparam int BW = $clog2(DIV);
    localparam logic [BW-1:0] FULL_BIT = BW'(DIV - 1);
    localparam logic [BW-1:0] ZERO     = BW'(0);
    localparam logic [BW-1:0] ONE      = BW'(1);

    tx_state_t     state_q, state_d;
    logic [BW-1:0] baud_q,  baud_d;
    logic [2:0]    bit_q,   bit_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          txd_q,   txd_d;

    assign txd_o  = txd_q;
    assign busy_o = (state_q != T_IDLE);

    // FSM state and the output flop; reset drives the line high immediately
    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            state_q <= T_IDLE;
            baud_q  <= {BW{1'b0}};
            bit_q   <= 3'd0;
            shreg_q <= 8'd0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            txd_q   <= txd_d;
        end
    end

    // Transmit FSM; every state lasts exactly DIV clocks
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        take_o  = 1'b0;
        txd_d   = 1'b1;
        case (state_q)
            T_IDLE: begin
                txd_d = 1'b1;
                if (hold_full_i) begin
                    take_o  = 1'b1;
                    shreg_d = hold_data_i;
                    baud_d  = FULL_BIT;
                    state_d = T_START;
                end else begin
                    state_d = T_IDLE;
                end
            end
            T_START: begin
                txd_d = 1'b0;
                if (baud_q == ZERO) begin
                    baud_d  = FULL_BIT;
                    bit_d   = 3'd0;
                    state_d = T_DATA;
                end else begin
                    baud_d = baud_q - ONE;
                end
            end
            T_DATA: begin
                txd_d = shreg_q[0];
                if (baud_q == ZERO) begin
                    baud_d  = FULL_BIT;
                    shreg_d = {1'b0, shreg_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = T_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q - ONE;
                end
            end
            T_STOP: begin
                txd_d = 1'b1;
                if (baud_q == ZERO) begin
                    // Chain straight into the next start bit when a byte waits
                    if (hold_full_i) begin
                        take_o  = 1'b1;
                        shreg_d = hold_data_i;
                        baud_d  = FULL_BIT;
                        state_d = T_START;
                    end else begin
                        state_d = T_IDLE;
                    end
                end else begin
                    baud_d = baud_q - ONE;
                end
            end
            default: begin
                state_d = T_IDLE;
                txd_d   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/rs232_avm_slave.sv
// Avalon-MM UART register file: RX data (0), TX data (4), STATUS (8), with a
// fixed one-wait-state responder, one-byte holding registers and sticky flags.
// Ports:
//   avm_clk, avm_rst              : clock, asynchronous active-high reset
//   avs_address/read/write/...    : Avalon-MM slave port, readdata registered
//   avs_waitrequest               : high on the first cycle of every access
//   uart_rxd / uart_txd           : board serial pins (txd idles high)
module rs232_avm_slave
    import rs232_pkg::*;
#(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200
) (
    input  logic        avm_clk,
    input  logic        avm_rst,
    input  logic [4:0]  avs_address,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic        avs_waitrequest,
    input  logic        uart_rxd,
    output logic        uart_txd
);

    localparam int DIV = (CLK_FREQ + BAUD / 2) / BAUD;

    logic        wait_q,     wait_d;
    logic [31:0] readdata_q, readdata_d;
    logic        rd_stale_q, rd_stale_d;
    logic [7:0]  rx_hold_q,  rx_hold_d;
    logic        rrdy_q,     rrdy_d;
    logic        roe_q,      roe_d;
    logic        fe_q,       fe_d;
    logic        toe_q,      toe_d;
    logic [7:0]  tx_hold_q,  tx_hold_d;
    logic        tx_full_q,  tx_full_d;

    logic        req_s, acc_s, rx_rd_acc_s, wr_acc_s;
    logic        rx_valid_s, rx_fe_s, tx_take_s, tx_busy_s;
    logic [7:0]  rx_data_s;
    logic        unused_wdata_s;

    assign avs_waitrequest = wait_q;
    assign avs_readdata    = readdata_q;
    assign unused_wdata_s  = ^avs_writedata[31:8];

    assign req_s       = avs_read | avs_write;
    assign acc_s       = req_s & ~wait_q;
    assign rx_rd_acc_s = acc_s & avs_read & (avs_address == RX_BASE);
    assign wr_acc_s    = acc_s & avs_write & ~avs_read;

    rs232_rx_core #(.DIV(DIV)) u_rx (
        .avm_clk (avm_clk),
        .avm_rst (avm_rst),
        .rxd_i   (uart_rxd),
        .valid_o (rx_valid_s),
        .data_o  (rx_data_s),
        .fe_o    (rx_fe_s)
    );

    rs232_tx_core #(.DIV(DIV)) u_tx (
        .avm_clk     (avm_clk),
        .avm_rst     (avm_rst),
        .hold_full_i (tx_full_q),
        .hold_data_i (tx_hold_q),
        .take_o      (tx_take_s),
        .busy_o      (tx_busy_s),
        .txd_o       (uart_txd)
    );

    // Bus responder and register-file state
    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            wait_q     <= 1'b1;
            readdata_q <= 32'd0;
            rd_stale_q <= 1'b0;
            rx_hold_q  <= 8'd0;
            rrdy_q     <= 1'b0;
            roe_q      <= 1'b0;
            fe_q       <= 1'b0;
            toe_q      <= 1'b0;
            tx_hold_q  <= 8'd0;
            tx_full_q  <= 1'b0;
        end else begin
            wait_q     <= wait_d;
            readdata_q <= readdata_d;
            rd_stale_q <= rd_stale_d;
            rx_hold_q  <= rx_hold_d;
            rrdy_q     <= rrdy_d;
            roe_q      <= roe_d;
            fe_q       <= fe_d;
            toe_q      <= toe_d;
            tx_hold_q  <= tx_hold_d;
            tx_full_q  <= tx_full_d;
        end
    end

    // One wait state: drop waitrequest the cycle after a request is first seen,
    // and register the read data during that first cycle
    always_comb begin
        wait_d     = ~(req_s & wait_q);
        readdata_d = readdata_q;
        rd_stale_d = 1'b0;
        if (avs_read && wait_q) begin
            case (avs_address)
                RX_BASE:     readdata_d = {24'd0, rx_hold_q};
                STATUS_BASE: readdata_d = status_word(rrdy_q, ~tx_full_q,
                                                      ~tx_full_q & ~tx_busy_s,
                                                      roe_q, fe_q, toe_q);
                default:     readdata_d = 32'd0;
            endcase
            // A byte delivered after the RX data was captured must not be
            // consumed by this read
            rd_stale_d = (avs_address == RX_BASE) & rx_valid_s;
        end else begin
            readdata_d = readdata_q;
        end
    end

    // Holding registers and flags; later assignments take priority so that a
    // new event in the same cycle as a STATUS clear is not lost
    always_comb begin
        rx_hold_d = rx_hold_q;
        rrdy_d    = rrdy_q;
        roe_d     = roe_q;
        fe_d      = fe_q;
        toe_d     = toe_q;
        tx_hold_d = tx_hold_q;
        tx_full_d = tx_full_q;

        if (rx_rd_acc_s && !rd_stale_q) begin
            rrdy_d = 1'b0;
        end else begin
            rrdy_d = rrdy_q;
        end

        if (wr_acc_s && (avs_address == STATUS_BASE)) begin
            roe_d = 1'b0;
            fe_d  = 1'b0;
            toe_d = 1'b0;
        end else begin
            roe_d = roe_q;
        end

        if (wr_acc_s && (avs_address == TX_BASE)) begin
            if (!tx_full_q) begin
                tx_hold_d = avs_writedata[7:0];
                tx_full_d = 1'b1;
            end else begin
                toe_d = 1'b1;
            end
        end else begin
            tx_hold_d = tx_hold_q;
        end

        // take only fires while full, so it never collides with a TX load
        if (tx_take_s) begin
            tx_full_d = 1'b0;
        end else begin
            tx_full_d = tx_full_d;
        end

        if (rx_valid_s) begin
            rx_hold_d = rx_data_s;
            rrdy_d    = 1'b1;
            // A read consuming the old byte in this cycle is not an overrun
            if (rrdy_q && !rx_rd_acc_s) begin
                roe_d = 1'b1;
            end else begin
                roe_d = roe_d;
            end
            if (rx_fe_s) begin
                fe_d = 1'b1;
            end else begin
                fe_d = fe_d;
            end
        end else begin
            rx_hold_d = rx_hold_d;
        end
    end

endmodule

// File: tb/tb_rs232_avm_slave.sv
// Self-checking bench for rs232_avm_slave at CLK_FREQ=160, BAUD=10 (DIV=16).
// Bus reads push their expected data to a scoreboard queue and pop it when
// waitrequest drops; transmitted bytes are decoded by a serial monitor and
// compared against the bytes queued when TX writes were issued.
`timescale 1ns/1ps
module tb_rs232_avm_slave;

    logic        avm_clk;
    logic        avm_rst;
    logic [4:0]  avs_address;
    logic        avs_read;
    logic [31:0] avs_readdata;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic        avs_waitrequest;
    logic        uart_rxd;
    logic        uart_txd;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];
    logic [7:0]  tx_exp[$];
    logic [7:0]  got_q[$];
    time         got_t[$];

    rs232_avm_slave #(.CLK_FREQ(160), .BAUD(10)) dut (
        .avm_clk         (avm_clk),
        .avm_rst         (avm_rst),
        .avs_address     (avs_address),
        .avs_read        (avs_read),
        .avs_readdata    (avs_readdata),
        .avs_write       (avs_write),
        .avs_writedata   (avs_writedata),
        .avs_waitrequest (avs_waitrequest),
        .uart_rxd        (uart_rxd),
        .uart_txd        (uart_txd)
    );

    initial avm_clk = 1'b0;
    always #5 avm_clk = ~avm_clk;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bus_xfer(input logic rd, input logic wr, input logic [4:0] addr,
                            input logic [31:0] wdata);
        int n;
        logic [31:0] e;
        string t;
        @(negedge avm_clk);
        avs_address   = addr;
        avs_read      = rd;
        avs_write     = wr;
        avs_writedata = wdata;
        #1;
        chk_eq("wait_first_cycle", 32'(avs_waitrequest), 32'd1);
        n = 0;
        do begin
            @(posedge avm_clk);
            #1;
            n++;
        end while (avs_waitrequest && n < 8);
        chk_eq("wait_states", 32'(n), 32'd1);
        if (rd) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            chk_eq(t, avs_readdata, e);
        end
        @(posedge avm_clk);
        #1;
        avs_read  = 1'b0;
        avs_write = 1'b0;
    endtask

    task automatic bus_read(input logic [4:0] addr, input logic [31:0] exp, input string tag);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        bus_xfer(1'b1, 1'b0, addr, 32'd0);
    endtask

    task automatic bus_write(input logic [4:0] addr, input logic [31:0] data);
        bus_xfer(1'b0, 1'b1, addr, data);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge avm_clk);
            uart_rxd = fr[i];
            repeat (15) @(negedge avm_clk);
        end
        @(negedge avm_clk);
        uart_rxd = 1'b1;
    endtask

    // Serial monitor on uart_txd: samples each bit at its middle
    initial begin
        forever begin
            logic [7:0] b;
            time t0;
            b = 8'd0;
            @(negedge uart_txd);
            t0 = $time;
            repeat (8) @(posedge avm_clk);
            for (int i = 0; i < 8; i++) begin
                repeat (16) @(posedge avm_clk);
                b[i] = uart_txd;
            end
            repeat (16) @(posedge avm_clk);
            if (uart_txd === 1'b1) begin
                got_q.push_back(b);
                got_t.push_back(t0);
            end
        end
    end

    initial begin
        avm_rst       = 1'b1;
        avs_address   = 5'd0;
        avs_read      = 1'b0;
        avs_write     = 1'b0;
        avs_writedata = 32'd0;
        uart_rxd      = 1'b1;
        repeat (3) @(posedge avm_clk);
        #1;
        chk_eq("rst_waitrequest", 32'(avs_waitrequest), 32'd1);
        chk_eq("rst_readdata", avs_readdata, 32'd0);
        chk_eq("rst_txd", 32'(uart_txd), 32'd1);
        @(negedge avm_clk);
        avm_rst = 1'b0;

        // Reset STATUS and unmapped address handling
        bus_read(5'd8, 32'h60, "status_reset");
        bus_read(5'd12, 32'h0, "unmapped_read");
        bus_write(5'd12, 32'hFF);
        bus_read(5'd8, 32'h60, "status_unmapped_wr");

        // Transmit 0xA5: exact waveform, early TRDY, TMT after the stop bit
        tx_exp.push_back(8'hA5);
        bus_write(5'd4, 32'hA5);
        fork
            begin
                int bad;
                logic [9:0] fr;
                logic expb;
                bad = 0;
                fr  = {1'b1, 8'hA5, 1'b0};
                for (int k = 0; k < 162; k++) begin
                    if (k < 2) expb = 1'b1;
                    else       expb = fr[(k - 2) / 16];
                    if (uart_txd !== expb) bad++;
                    @(posedge avm_clk);
                    #1;
                end
                chk_eq("tx_a5_waveform_bad_cycles", 32'(bad), 32'd0);
            end
            begin
                @(posedge avm_clk);
                bus_read(5'd8, 32'h40, "trdy_early");
            end
        join
        bus_read(5'd8, 32'h60, "tmt_after_stop");

        // Receive 0x3C: RRDY only after the stop sample
        fork
            send_rx(8'h3C, 1'b1);
            begin
                repeat (144) @(posedge avm_clk);
                bus_read(5'd8, 32'h60, "rrdy_not_yet");
            end
        join
        bus_read(5'd8, 32'hE0, "rrdy_set");
        bus_read(5'd0, 32'h3C, "rx_3c");
        bus_read(5'd8, 32'h60, "rrdy_cleared");
        bus_read(5'd0, 32'h3C, "rx_reread_empty");

        // Overrun: two frames back-to-back without reading
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        bus_read(5'd8, 32'hE8, "roe_set");
        bus_read(5'd0, 32'h22, "rx_overrun_byte");
        bus_write(5'd8, 32'h0);
        bus_read(5'd8, 32'h60, "roe_cleared");

        // Framing error, read-wins on simultaneous read/write, glitch rejection
        send_rx(8'h5A, 1'b0);
        repeat (32) @(negedge avm_clk);
        exp_q.push_back(32'hE4);
        tag_q.push_back("read_wins_status");
        bus_xfer(1'b1, 1'b1, 5'd8, 32'h0);
        bus_read(5'd8, 32'hE4, "fe_still_set");
        bus_read(5'd0, 32'h5A, "rx_fe_byte");
        bus_write(5'd8, 32'h0);
        @(negedge avm_clk);
        uart_rxd = 1'b0;
        repeat (4) @(negedge avm_clk);
        uart_rxd = 1'b1;
        repeat (100) @(negedge avm_clk);
        bus_read(5'd8, 32'h60, "glitch_ignored");

        // Back-to-back TX writes plus an overflowing third write
        tx_exp.push_back(8'h01);
        tx_exp.push_back(8'h02);
        bus_write(5'd4, 32'h01);
        bus_write(5'd4, 32'h02);
        bus_write(5'd4, 32'h03);
        bus_read(5'd8, 32'h02, "toe_set");
        repeat (360) @(posedge avm_clk);
        bus_read(5'd8, 32'h62, "tx_done_toe_sticky");
        chk_eq("tx_frame_count", 32'(got_q.size()), 32'(tx_exp.size()));
        for (int i = 0; i < tx_exp.size(); i++) begin
            chk_eq($sformatf("tx_byte_%0d", i),
                   (i < got_q.size()) ? 32'(got_q[i]) : 32'hDEAD, 32'(tx_exp[i]));
        end
        if (got_t.size() >= 3) begin
            chk_eq("tx_contiguous_ns", 32'(got_t[2] - got_t[1]), 32'd1600);
        end else begin
            chk_eq("tx_contiguous_frames", 32'(got_t.size()), 32'd3);
        end
        bus_write(5'd8, 32'h0);

        // Reset in the middle of a start bit
        bus_write(5'd4, 32'h55);
        repeat (5) @(posedge avm_clk);
        #1;
        chk_eq("txd_low_before_rst", 32'(uart_txd), 32'd0);
        #2;
        avm_rst = 1'b1;
        #1;
        chk_eq("txd_async_rst", 32'(uart_txd), 32'd1);
        chk_eq("wait_in_rst", 32'(avs_waitrequest), 32'd1);
        chk_eq("readdata_in_rst", avs_readdata, 32'd0);
        repeat (2) @(negedge avm_clk);
        avm_rst = 1'b0;
        bus_read(5'd8, 32'h60, "status_after_rst");
        bus_read(5'd0, 32'h0, "rx_after_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
